// File: rtl/pic_ack_sequencer_if.sv
// Bus between the IRR/CPU side and the PIC acknowledge sequencer:
// request and INTA/EOI inputs, INT, ISR, IRR-clear strobe and vector-bus outputs.
interface pic_ack_sequencer_if #(
  parameter int unsigned VEC_HI_W = 5
);
  logic [7:0]          irr;
  logic                inta_n;
  logic [VEC_HI_W-1:0] vector_base;
  logic                auto_eoi;
  logic                eoi;
  logic                eoi_specific;
  logic [2:0]          eoi_level;
  logic                int_out;
  logic [7:0]          isr;
  logic                irr_clear;
  logic [7:0]          irr_clear_mask;
  logic [7:0]          data_out;
  logic                data_oe;

  modport master (
    output irr, inta_n, vector_base, auto_eoi, eoi, eoi_specific, eoi_level,
    input  int_out, isr, irr_clear, irr_clear_mask, data_out, data_oe
  );

  modport slave (
    input  irr, inta_n, vector_base, auto_eoi, eoi, eoi_specific, eoi_level,
    output int_out, isr, irr_clear, irr_clear_mask, data_out, data_oe
  );
endinterface

// File: rtl/pic_ack_sequencer.sv
// Fully nested 8259-style acknowledge sequencer: priority resolution against
// the ISR, INT generation, two-pulse INTA handling, vector drive and EOI.
module pic_ack_sequencer #(
  parameter int unsigned VEC_HI_W     = 5,
  parameter int unsigned SPURIOUS_LVL = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pic_ack_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT1 = 2'd1,
    ACK1  = 2'd2,
    ACK2  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                inta_prev_q, inta_prev_d;
  logic                int_out_q, int_out_d;
  logic [7:0]          isr_q, isr_d;
  logic                irr_clear_q, irr_clear_d;
  logic [7:0]          irr_clear_mask_q, irr_clear_mask_d;
  logic [7:0]          data_out_q, data_out_d;
  logic                data_oe_q, data_oe_d;
  logic [2:0]          ack_lvl_q, ack_lvl_d;
  logic                spurious_q, spurious_d;

  logic [VEC_HI_W-1:0] vbase;
  logic                inta_fall, inta_rise;
  logic [2:0]          req_lvl;
  logic [3:0]          svc_lvl;
  logic                req_ok;

  assign vbase     = bus.vector_base;
  assign inta_fall = inta_prev_q & ~bus.inta_n;
  assign inta_rise = ~inta_prev_q & bus.inta_n;

  // Scan from IR7 down so the lowest set index wins.
  always_comb begin
    req_lvl = '0;
    svc_lvl = 4'd8;
    for (int unsigned i = 0; i < 8; i++) begin
      if (bus.irr[7-i]) req_lvl = 3'(7-i);
      if (isr_q[7-i])   svc_lvl = 4'(7-i);
    end
  end

  assign req_ok = (bus.irr != '0) && ({1'b0, req_lvl} < svc_lvl);

  always_comb begin
    state_d          = state_q;
    inta_prev_d      = bus.inta_n;
    int_out_d        = int_out_q;
    isr_d            = isr_q;
    irr_clear_d      = 1'b0;
    irr_clear_mask_d = '0;
    data_out_d       = data_out_q;
    data_oe_d        = data_oe_q;
    ack_lvl_d        = ack_lvl_q;
    spurious_d       = spurious_q;

    // EOI clears land first so a same-cycle acknowledge set survives.
    if (bus.eoi) begin
      if (bus.eoi_specific)  isr_d[bus.eoi_level]  = 1'b0;
      else if (!svc_lvl[3])  isr_d[svc_lvl[2:0]]   = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (req_ok) begin
          int_out_d = 1'b1;
          state_d   = WAIT1;
        end
      end
      WAIT1: begin
        if (inta_fall) begin
          if (req_ok) begin
            ack_lvl_d        = req_lvl;
            spurious_d       = 1'b0;
            isr_d[req_lvl]   = 1'b1;
            irr_clear_d      = 1'b1;
            irr_clear_mask_d = 8'(1) << req_lvl;
          end else begin
            ack_lvl_d  = 3'(SPURIOUS_LVL);
            spurious_d = 1'b1;
          end
          int_out_d = 1'b0;
          state_d   = ACK1;
        end
      end
      ACK1: begin
        if (inta_fall) begin
          data_out_d = 8'({vbase, ack_lvl_q});
          data_oe_d  = 1'b1;
          state_d    = ACK2;
        end
      end
      ACK2: begin
        if (inta_rise) begin
          data_oe_d = 1'b0;
          if (bus.auto_eoi && !spurious_q) isr_d[ack_lvl_q] = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      inta_prev_q      <= 1'b1;
      int_out_q        <= 1'b0;
      isr_q            <= '0;
      irr_clear_q      <= 1'b0;
      irr_clear_mask_q <= '0;
      data_out_q       <= '0;
      data_oe_q        <= 1'b0;
      ack_lvl_q        <= '0;
      spurious_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      inta_prev_q      <= inta_prev_d;
      int_out_q        <= int_out_d;
      isr_q            <= isr_d;
      irr_clear_q      <= irr_clear_d;
      irr_clear_mask_q <= irr_clear_mask_d;
      data_out_q       <= data_out_d;
      data_oe_q        <= data_oe_d;
      ack_lvl_q        <= ack_lvl_d;
      spurious_q       <= spurious_d;
    end
  end

  assign bus.int_out        = int_out_q;
  assign bus.isr            = isr_q;
  assign bus.irr_clear      = irr_clear_q;
  assign bus.irr_clear_mask = irr_clear_mask_q;
  assign bus.data_out       = data_out_q;
  assign bus.data_oe        = data_oe_q;

endmodule

// File: tb/tb_pic_ack_sequencer.sv
// Bench for pic_ack_sequencer: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_pic_ack_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  pic_ack_sequencer_if #(.VEC_HI_W(5)) bus ();

  pic_ack_sequencer #(.VEC_HI_W(5), .SPURIOUS_LVL(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- behavioural model ----------------
  // m_stage counts how far the CPU has progressed through one interrupt:
  // 0 nothing pending, 1 INT raised, 2 first INTA taken, 3 vector on bus.
  logic [7:0] m_isr, m_mask, m_dout;
  logic       m_int, m_clr, m_doe, m_prev, m_spur;
  int         m_stage, m_lvl;

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 8;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_isr = '0; m_mask = '0; m_dout = '0;
      m_int = 0; m_clr = 0; m_doe = 0; m_prev = 1; m_spur = 0;
      m_stage = 0; m_lvl = 0;
    end else begin
      bit   fall, rise, ok;
      int   req, svc;
      logic [7:0] nisr;
      fall = m_prev && !bus.inta_n;
      rise = !m_prev && bus.inta_n;
      req  = lowest(bus.irr);
      svc  = lowest(m_isr);
      ok   = (req < 8) && (req < svc);
      nisr = m_isr;
      m_clr = 0;
      m_mask = '0;
      if (bus.eoi) begin
        if (bus.eoi_specific) nisr[bus.eoi_level] = 1'b0;
        else if (svc < 8)     nisr[svc] = 1'b0;
      end
      if (m_stage == 0) begin
        if (ok) begin m_int = 1; m_stage = 1; end
      end else if (m_stage == 1) begin
        if (fall) begin
          if (ok) begin
            m_lvl = req; m_spur = 0; nisr[req] = 1'b1;
            m_clr = 1; m_mask = 8'(1 << req);
          end else begin
            m_lvl = 7; m_spur = 1;
          end
          m_int = 0; m_stage = 2;
        end
      end else if (m_stage == 2) begin
        if (fall) begin
          m_dout = {bus.vector_base, 3'(m_lvl)};
          m_doe = 1; m_stage = 3;
        end
      end else begin
        if (rise) begin
          m_doe = 0;
          if (bus.auto_eoi && !m_spur) nisr[m_lvl] = 1'b0;
          m_stage = 0;
        end
      end
      m_isr  = nisr;
      m_prev = bus.inta_n;
    end
  end

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check8("model_int_out",   8'(bus.int_out),   8'(m_int));
    check8("model_isr",       bus.isr,           m_isr);
    check8("model_irr_clear", 8'(bus.irr_clear), 8'(m_clr));
    check8("model_clr_mask",  bus.irr_clear_mask, m_mask);
    check8("model_data_out",  bus.data_out,      m_dout);
    check8("model_data_oe",   8'(bus.data_oe),   8'(m_doe));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.inta_n = 1'b1;
    bus.eoi = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic ack_seq(input logic [7:0] irr_after);
    bus.inta_n = 1'b0; tick();
    bus.irr = irr_after;
    bus.inta_n = 1'b1; tick();
    bus.inta_n = 1'b0; tick();
    bus.inta_n = 1'b1; tick();
  endtask

  task automatic pulse_eoi(input logic spec, input logic [2:0] lvl);
    bus.eoi = 1'b1; bus.eoi_specific = spec; bus.eoi_level = lvl;
    tick();
    bus.eoi = 1'b0;
  endtask

  int q[$];

  initial begin
    bus.irr = '0; bus.inta_n = 1'b1; bus.vector_base = 5'b01000;
    bus.auto_eoi = 1'b0; bus.eoi = 1'b0; bus.eoi_specific = 1'b0; bus.eoi_level = '0;
    do_reset();
    check8("reset_isr", bus.isr, 8'h00);
    check8("reset_int", 8'(bus.int_out), 8'h00);
    check8("reset_oe",  8'(bus.data_oe), 8'h00);
    tick();

    // Single request on IR5, full acknowledge.
    bus.irr = 8'h20; tick();
    check8("t1_int", 8'(bus.int_out), 8'h01);
    bus.inta_n = 1'b0; tick();
    check8("t1_isr", bus.isr, 8'h20);
    check8("t1_clr", 8'(bus.irr_clear), 8'h01);
    check8("t1_mask", bus.irr_clear_mask, 8'h20);
    check8("t1_int_drop", 8'(bus.int_out), 8'h00);
    bus.irr = 8'h00; bus.inta_n = 1'b1; tick();
    check8("t1_clr_pulse", 8'(bus.irr_clear), 8'h00);
    bus.inta_n = 1'b0; tick();
    check8("t1_vec", bus.data_out, 8'h45);
    check8("t1_oe", 8'(bus.data_oe), 8'h01);
    tick();
    check8("t1_oe_hold", 8'(bus.data_oe), 8'h01);
    bus.inta_n = 1'b1; tick();
    check8("t1_oe_off", 8'(bus.data_oe), 8'h00);
    check8("t1_isr_kept", bus.isr, 8'h20);

    // IR1 beats IR3; IR3 re-raises INT only after EOI.
    do_reset();
    bus.irr = 8'h0A; tick();
    ack_seq(8'h08);
    check8("t2_isr", bus.isr, 8'h02);
    check8("t2_vec", bus.data_out, 8'h41);
    tick();
    check8("t2_no_int", 8'(bus.int_out), 8'h00);
    pulse_eoi(1'b0, 3'd0);
    check8("t2_eoi", bus.isr, 8'h00);
    tick();
    check8("t2_reint", 8'(bus.int_out), 8'h01);

    // Nesting: IR0 preempts IR2 in service.
    do_reset();
    bus.irr = 8'h04; tick();
    ack_seq(8'h10);
    check8("t3_isr", bus.isr, 8'h04);
    tick(); tick();
    check8("t3_blocked", 8'(bus.int_out), 8'h00);
    bus.irr = 8'h11; tick();
    check8("t3_int", 8'(bus.int_out), 8'h01);
    ack_seq(8'h10);
    check8("t3_nested", bus.isr, 8'h05);
    check8("t3_vec", bus.data_out, 8'h40);
    pulse_eoi(1'b0, 3'd0);
    check8("t3_eoi", bus.isr, 8'h04);

    // Spurious: request vanishes before first INTA.
    do_reset();
    bus.irr = 8'h02; tick();
    bus.irr = 8'h00; tick();
    check8("t4_int_held", 8'(bus.int_out), 8'h01);
    bus.inta_n = 1'b0; tick();
    check8("t4_isr", bus.isr, 8'h00);
    check8("t4_no_clr", 8'(bus.irr_clear), 8'h00);
    bus.inta_n = 1'b1; tick();
    bus.inta_n = 1'b0; tick();
    check8("t4_vec", bus.data_out, 8'h47);
    bus.inta_n = 1'b1; tick();

    // Auto-EOI, then specific EOI on a two-bit ISR.
    do_reset();
    bus.auto_eoi = 1'b1;
    bus.irr = 8'h80; tick();
    ack_seq(8'h00);
    check8("t5_auto", bus.isr, 8'h00);
    bus.auto_eoi = 1'b0;
    bus.irr = 8'h08; tick();
    ack_seq(8'h00);
    bus.irr = 8'h04; tick();
    ack_seq(8'h00);
    check8("t5_isr", bus.isr, 8'h0C);
    pulse_eoi(1'b1, 3'd3);
    check8("t5_spec", bus.isr, 8'h04);

    // Reset in the middle of the vector phase.
    do_reset();
    bus.irr = 8'h02; tick();
    bus.inta_n = 1'b0; tick();
    bus.irr = 8'h00; bus.inta_n = 1'b1; tick();
    bus.inta_n = 1'b0; tick();
    check8("t6_oe", 8'(bus.data_oe), 8'h01);
    rst_n = 1'b0; #1;
    check8("t6_async_oe", 8'(bus.data_oe), 8'h00);
    check8("t6_async_isr", bus.isr, 8'h00);
    check8("t6_async_int", 8'(bus.int_out), 8'h00);
    bus.irr = 8'h01; bus.inta_n = 1'b1; tick();
    rst_n = 1'b1; tick();
    check8("t6_reint", 8'(bus.int_out), 8'h01);

    // Randomized traffic; the negedge compare process does the checking.
    do_reset();
    bus.irr = '0;
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        q.delete();
        do_reset();
      end
      if ($urandom_range(0, 199) == 0) bus.auto_eoi = ~bus.auto_eoi;
      if ($urandom_range(0, 299) == 0) bus.vector_base = 5'($urandom);
      if (bus.irr_clear) bus.irr = bus.irr & ~bus.irr_clear_mask;
      if ($urandom_range(0, 7) == 0) bus.irr = 8'($urandom) & 8'($urandom) & 8'($urandom);
      bus.eoi = ($urandom_range(0, 11) == 0);
      bus.eoi_specific = 1'($urandom);
      bus.eoi_level = 3'($urandom);
      if (q.size() == 0) begin
        if (bus.int_out && $urandom_range(0, 2) == 0) begin
          int l1, g, l2;
          l1 = $urandom_range(1, 3); g = $urandom_range(1, 3); l2 = $urandom_range(1, 3);
          for (int k = 0; k < l1; k++) q.push_back(0);
          for (int k = 0; k < g; k++)  q.push_back(1);
          for (int k = 0; k < l2; k++) q.push_back(0);
          q.push_back(1);
        end else if ($urandom_range(0, 49) == 0) begin
          q.push_back(0);
          q.push_back(1);
        end
      end
      bus.inta_n = (q.size() != 0) ? 1'(q.pop_front()) : 1'b1;
      tick();
    end
    bus.eoi = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
